sevenseg_scan_driver: RTL

Parametrised N-digit time-multiplexed seven-segment scan driver. Generalises the two-digit driver to:
- NUM_DIGITS digits, with independent segment and digit-select polarity.
- Per-digit decimal points.
- Leading-zero blanking.
- PWM brightness control and an anti-ghosting dead time between digits.
- Tear-free frame-synchronous data update.

It sits between the counter/data logic and the PMOD pads.

---
 rtl/sevenseg_pkg.sv | 34 +++
 rtl/sevenseg_hex_decoder.sv | 11 +
 rtl/sevenseg_scan_driver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants and hex decode table.
// Patterns are active-high, bit order {a,b,c,d,e,f,g} with a at bit SEG_W-1.
package sevenseg_pkg;

    localparam int SEG_W = 7;
    localparam int SEG_A_BIT = SEG_W - 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [SEG_W-1:0] SEG_OFF = '0;

    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b1000111,
        7'b1001111,
        7'b0111101,
        7'b1001110,
        7'b0011111,
        7'b1110111,
        7'b1111011,
        7'b1111111,
        7'b1110000,
        7'b1011111,
        7'b1011011,
        7'b0110011,
        7'b1111001,
        7'b1101101,
        7'b0110000,
        7'b1111110
    };

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_hex_decoder.sv
// Combinational hex nibble to active-high segment pattern.
module sevenseg_hex_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] pattern
);

    assign pattern = seg_decode(nibble);

endmodule

// File: rtl/sevenseg_scan_driver.sv
// N-digit multiplexed seven-segment scanner with PWM dimming,
// dead time, leading-zero blanking and frame-synchronous updates.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 256,
    parameter int BLANK_CYCLES    = 8,
    parameter int BRIGHT_W        = 4,
    parameter bit SEG_ACTIVE_HIGH = 1'b1,
    parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    lz_blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [SEG_W-1:0]      SEG_IDLE = SEG_ACTIVE_HIGH ? SEG_OFF : ~SEG_OFF;
    localparam logic                  DP_IDLE  = !SEG_ACTIVE_HIGH;
    localparam logic [NUM_DIGITS-1:0] SEL_NONE = '0;
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE = SEL_ACTIVE_HIGH ? SEL_NONE : ~SEL_NONE;

    logic [SLOT_W-1:0]     slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [DATA_W-1:0]     pend_data;
    logic [DATA_W-1:0]     shadow_data;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic                  pend_valid;

    logic                  slot_end;
    logic                  frame_end;
    logic [BRIGHT_W-1:0]   phase;
    logic                  lit;
    logic                  blanked;
    logic [3:0]            nibble;
    logic [SEG_W-1:0]      pattern;
    logic [SEG_W-1:0]      seg_ah;
    logic                  dp_ah;
    logic [NUM_DIGITS-1:0] sel_ah;

    assign slot_end  = slot_cnt == SLOT_MAX;
    assign frame_end = slot_end && dig_idx == IDX_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end)
                dig_idx <= frame_end ? '0 : dig_idx + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pending and shows next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data   <= '0;
            pend_dp     <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend_valid  <= 1'b0;
        end else if (load && frame_end) begin
            shadow_data <= data_in;
            shadow_dp   <= dp_in;
            pend_valid  <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
                pend_valid  <= 1'b0;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    assign phase   = slot_cnt[SLOT_W-1 -: BRIGHT_W];
    assign lit     = enable && slot_cnt >= BLANK_END && phase <= brightness;
    assign nibble  = shadow_data[{dig_idx, 2'b00} +: 4];
    assign blanked = lz_blank && dig_idx != '0
                  && (shadow_data >> {dig_idx, 2'b00}) == '0;

    sevenseg_hex_decoder u_dec (
        .nibble  (nibble),
        .pattern (pattern)
    );

    always_comb begin
        seg_ah = SEG_OFF;
        dp_ah  = 1'b0;
        sel_ah = '0;
        if (lit) begin
            sel_ah[dig_idx] = 1'b1;
            dp_ah           = shadow_dp[dig_idx];
            if (!blanked)
                seg_ah = pattern;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_IDLE;
            dp         <= DP_IDLE;
            digit_sel  <= SEL_IDLE;
            frame_done <= 1'b0;
        end else begin
            seg        <= SEG_ACTIVE_HIGH ? seg_ah : ~seg_ah;
            dp         <= SEG_ACTIVE_HIGH ? dp_ah : ~dp_ah;
            digit_sel  <= SEL_ACTIVE_HIGH ? sel_ah : ~sel_ah;
            frame_done <= frame_end;
        end
    end

endmodule
